// File: rtl/mips_muldiv_pkg.sv
// mips_muldiv_pkg: shared types for the multiply/divide unit.
//   muldiv_op_t    - 3-bit request opcode
//   muldiv_state_t - FSM state encoding (IDLE/RUN/FIX) as legacy localparams
//   op_is_*        - opcode class helpers
package mips_muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } muldiv_op_t;

   typedef logic [1:0] muldiv_state_t;

   localparam muldiv_state_t ST_IDLE = 2'd0;
   localparam muldiv_state_t ST_RUN  = 2'd1;
   localparam muldiv_state_t ST_FIX  = 2'd2;

   // Divide class (DIV/DIVU)
   function automatic logic op_is_div(input muldiv_op_t op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // Signed class (MULT/DIV)
   function automatic logic op_is_signed(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   // Iterative ops that occupy the unit
   function automatic logic op_is_iter(input muldiv_op_t op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// mips_muldiv_if: request/response bundle between the core (master) and the
// multiply/divide unit (slave).
//   req_valid/req_op/req_a/req_b/flush : core -> unit
//   req_ready/busy/done/hi/lo          : unit -> core
interface mips_muldiv_if
   import mips_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);
   logic             req_valid;
   muldiv_op_t       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_ready;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output req_valid, req_op, req_a, req_b, flush,
      input  req_ready, busy, done, hi, lo
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush,
      output req_ready, busy, done, hi, lo
   );
endinterface

// File: rtl/mips_muldiv_iter.sv
// mips_muldiv_iter: one combinational step of the iterative datapath.
//   is_div_i           : 1 = restoring-divide step, 0 = shift/add multiply step
//   acc_i/acc_o        : multiply accumulator, or {remainder, dividend/quotient}
//   mcand_i/mcand_o    : shifted multiplicand, or divisor in the low half
//   mplier_i/mplier_o  : multiplier magnitude, shifted right each step
module mips_muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               is_div_i,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [2*WIDTH-1:0] mcand_i,
   input  logic [WIDTH-1:0]   mplier_i,
   output logic [2*WIDTH-1:0] acc_o,
   output logic [2*WIDTH-1:0] mcand_o,
   output logic [WIDTH-1:0]   mplier_o
);

   logic [WIDTH:0]   partial;
   logic [WIDTH-1:0] diff;
   logic             ge;

   // Remainder shifted left with the next dividend bit brought in
   assign partial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
   assign ge      = partial >= {1'b0, mcand_i[WIDTH-1:0]};
   // Only used when ge, where the true difference always fits in WIDTH bits
   assign diff    = partial[WIDTH-1:0] - mcand_i[WIDTH-1:0];

   // Step select
   always_comb begin
      acc_o    = acc_i;
      mcand_o  = mcand_i;
      mplier_o = mplier_i;
      if (is_div_i) begin
         acc_o = {(ge ? diff : partial[WIDTH-1:0]), acc_i[WIDTH-2:0], ge};
      end else begin
         if (mplier_i[0]) begin
            acc_o = acc_i + mcand_i;
         end
         mcand_o  = mcand_i << 1;
         mplier_o = mplier_i >> 1;
      end
   end

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers;
// MTHI/MTLO write HI/LO in a single cycle.
//   clk   : clock
//   rst_b : asynchronous active-low reset
//   bus   : mips_muldiv_if.slave (request, flush, ready/busy/done, hi/lo)
// Build option MULDIV_EARLY_OUT_EN: a multiply leaves RUN as soon as the
// remaining multiplier magnitude is zero (at least one RUN cycle).
module mips_muldiv
   import mips_muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic         clk,
   input logic         rst_b,
   mips_muldiv_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   muldiv_state_t      state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   a_raw_q, a_raw_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;

   logic [2*WIDTH-1:0] acc_nx, mcand_nx;
   logic [WIDTH-1:0]   mplier_nx;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   logic               run_last;

   mips_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .mcand_i  (mcand_q),
      .mplier_i (mplier_q),
      .acc_o    (acc_nx),
      .mcand_o  (mcand_nx),
      .mplier_o (mplier_nx)
   );

   // Operand magnitudes and sign flags at accept
   assign a_neg = op_is_signed(bus.req_op) & bus.req_a[WIDTH-1];
   assign b_neg = op_is_signed(bus.req_op) & bus.req_b[WIDTH-1];
   assign a_mag = a_neg ? -bus.req_a : bus.req_a;
   assign b_mag = b_neg ? -bus.req_b : bus.req_b;

   // Sign-corrected results for the FIX cycle
   assign prod_fix = neg_res_q ? -acc_q : acc_q;
   assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
   assign run_last = (cnt_q == '0) || (!is_div_q && (mplier_nx == '0));
`else
   assign run_last = (cnt_q == '0);
`endif

   // Next-state and datapath control
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      a_raw_d   = a_raw_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && !bus.flush) begin
               if (bus.req_op == MD_MTHI) begin
                  hi_d = bus.req_a;
               end else if (bus.req_op == MD_MTLO) begin
                  lo_d = bus.req_a;
               end else if (op_is_iter(bus.req_op)) begin
                  state_d   = ST_RUN;
                  cnt_d     = CNT_W'(WIDTH - 1);
                  is_div_d  = op_is_div(bus.req_op);
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  div0_d    = op_is_div(bus.req_op) && (bus.req_b == '0);
                  a_raw_d   = bus.req_a;
                  if (op_is_div(bus.req_op)) begin
                     acc_d    = {{WIDTH{1'b0}}, a_mag};
                     mcand_d  = {{WIDTH{1'b0}}, b_mag};
                     mplier_d = '0;
                  end else begin
                     acc_d    = '0;
                     mcand_d  = {{WIDTH{1'b0}}, a_mag};
                     mplier_d = b_mag;
                  end
               end
            end
         end
         ST_RUN: begin
            if (bus.flush) begin
               state_d = ST_IDLE;
            end else begin
               acc_d    = acc_nx;
               mcand_d  = mcand_nx;
               mplier_d = mplier_nx;
               if (run_last) begin
                  state_d = ST_FIX;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end
         ST_FIX: begin
            state_d = ST_IDLE;
            if (!bus.flush) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod_fix;
               end else if (div0_q) begin
                  hi_d = a_raw_q;
                  lo_d = {WIDTH{1'b1}};
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d  = (state_d != ST_IDLE);
      ready_d = (state_d == ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         a_raw_q   <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         a_raw_q   <= a_raw_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.hi        = hi_q;
   assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: directed vectors for mips_muldiv, checked cycle by cycle
// against a transaction-level model (result arithmetic plus latency count).
module tb_mips_muldiv;
   import mips_muldiv_pkg::*;

   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic chk_en = 1'b0;
   int   n_vec = 0;
   int   n_fail = 0;

   mips_muldiv_if #(.WIDTH(W)) bus ();

   mips_muldiv #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference result {hi,lo} from plain integer arithmetic
   function automatic logic [63:0] model_res(input muldiv_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      int              q, r;
      logic [63:0]     res;
      res = '0;
      case (op)
         MD_MULT: begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            res = 64'(sa * sb);
         end
         MD_MULTU: begin
            ua  = {32'd0, a};
            ub  = {32'd0, b};
            res = 64'(ua * ub);
         end
         MD_DIV: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
            else begin
               q   = $signed(a) / $signed(b);
               r   = $signed(a) % $signed(b);
               res = {32'(r), 32'(q)};
            end
         end
         MD_DIVU: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   // Edges from accept until the HI/LO write
   function automatic int model_lat(input muldiv_op_t op, input logic [31:0] b);
      int          k;
      logic [31:0] mag;
      k   = W;
      mag = b;
`ifdef MULDIV_EARLY_OUT_EN
      if (op == MD_MULT || op == MD_MULTU) begin
         if (op == MD_MULT && b[31]) mag = -b;
         k = 1;
         for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
      end
`else
      if (op == MD_MULT) mag = b;
`endif
      return k + 1;
   endfunction

   // Model state
   int          m_left;
   logic [31:0] m_hi, m_lo;
   logic        m_done;
   logic [63:0] m_res;

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         m_left <= 0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_done <= 1'b0;
         m_res  <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_left != 0) begin
            if (bus.flush) m_left <= 0;
            else begin
               m_left <= m_left - 1;
               if (m_left == 1) begin
                  m_hi   <= m_res[63:32];
                  m_lo   <= m_res[31:0];
                  m_done <= 1'b1;
               end
            end
         end else if (bus.req_valid && !bus.flush) begin
            case (bus.req_op)
               MD_MTHI: m_hi <= bus.req_a;
               MD_MTLO: m_lo <= bus.req_a;
               MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                  m_res  <= model_res(bus.req_op, bus.req_a, bus.req_b);
                  m_left <= model_lat(bus.req_op, bus.req_b);
               end
               default: ;
            endcase
         end
      end
   end

   // Per-cycle compare of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_busy",  bus.busy,      (m_left != 0));
         chk("cyc_ready", bus.req_ready, (m_left == 0));
         chk("cyc_done",  bus.done,      m_done);
         chk("cyc_hi",    bus.hi,        m_hi);
         chk("cyc_lo",    bus.lo,        m_lo);
      end
   end

   // Present a request and hold it until accepted; returns just after E0
   task automatic issue(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
      int guard;
      guard = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      while (!bus.req_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   // Count edges after E0 until done is seen
   task automatic wait_done(output int n);
      logic got;
      got = 1'b0;
      n   = 0;
      while (!got && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (bus.done) got = 1'b1;
      end
      chk("done_seen", got, 1'b1);
   endtask

   typedef struct {
      muldiv_op_t  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat_eo;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int n, lat, ndone;
      vecs[0]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
      vecs[1]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
      vecs[2]  = '{MD_DIVU,  32'd100,       32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 33};
      vecs[3]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
      vecs[4]  = '{MD_MULTU, 32'd5,         32'd3,         32'h0000_0000, 32'h0000_000F, 3};
      vecs[5]  = '{MD_MULTU, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2};
      vecs[6]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
      vecs[7]  = '{MD_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33};
      vecs[8]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
      vecs[9]  = '{MD_MULT,  32'd5,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 3};
      vecs[10] = '{MD_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 33};
      vecs[11] = '{MD_MULT,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};

      bus.req_valid = 1'b0;
      bus.req_op    = MD_MULT;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.flush     = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", bus.req_ready, 1'b1);
      chk("rst_busy",  bus.busy,      1'b0);
      chk("rst_done",  bus.done,      1'b0);
      chk("rst_hi",    bus.hi,        32'h0);
      chk("rst_lo",    bus.lo,        32'h0);
      rst_b  = 1'b1;
      chk_en = 1'b1;

      // MULT -3*7 with an MTHI held while busy
      issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
      bus.req_valid = 1'b1;
      bus.req_op    = MD_MTHI;
      bus.req_a     = 32'h0000_1234;
      @(negedge clk);
      chk("mthi_blocked_ready", bus.req_ready, 1'b0);
      wait_done(n);
`ifdef MULDIV_EARLY_OUT_EN
      chk("mult_lat", 64'(n), 64'd4);
`else
      chk("mult_lat", 64'(n), 64'd33);
`endif
      chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
      chk("mult_lo", bus.lo, 32'hFFFF_FFEB);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      chk("mthi_hi", bus.hi, 32'h0000_1234);
      chk("mthi_lo", bus.lo, 32'hFFFF_FFEB);

      issue(MD_MTLO, 32'h0000_55AA, 32'd0);
      @(negedge clk);
      chk("mtlo_lo", bus.lo, 32'h0000_55AA);

      // Flush during RUN cycle 10, with an ignored same-cycle request
      issue(MD_MULT, 32'd3, 32'h0000_FFFF);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush     = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_MTHI;
      bus.req_a     = 32'h0000_DEAD;
      @(posedge clk);
      #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("flush_ready", bus.req_ready, 1'b1);
      chk("flush_busy",  bus.busy,      1'b0);
      chk("flush_hi",    bus.hi,        32'h0000_1234);
      chk("flush_lo",    bus.lo,        32'h0000_55AA);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      chk("flush_no_done", 64'(ndone), 64'd0);

      // Flush while idle blocks the request
      @(negedge clk);
      bus.flush     = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = MD_MTHI;
      bus.req_a     = 32'h0000_BEEF;
      @(posedge clk);
      #1;
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("idle_flush_hi", bus.hi, 32'h0000_1234);

      // Asynchronous reset mid-operation
      issue(MD_MULT, 32'd7, 32'h0000_FFFF);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("arst_hi",    bus.hi,        32'h0);
      chk("arst_lo",    bus.lo,        32'h0);
      chk("arst_ready", bus.req_ready, 1'b1);
      chk("arst_busy",  bus.busy,      1'b0);
      @(negedge clk);
      rst_b = 1'b1;

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_done(n);
`ifdef MULDIV_EARLY_OUT_EN
         lat = vecs[i].lat_eo;
`else
         lat = 33;
`endif
         chk($sformatf("v%0d_lat", i), 64'(n), 64'(lat));
         chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
         chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
      end

      // A few extra operand patterns against the model
      for (int i = 0; i < 6; i++) begin
         muldiv_op_t  rop;
         logic [31:0] ra, rb;
         logic [63:0] rres;
         rop  = muldiv_op_t'(3'($urandom_range(0, 3)));
         ra   = $urandom;
         rb   = (i == 0) ? 32'd0 : $urandom;
         rres = model_res(rop, ra, rb);
         issue(rop, ra, rb);
         wait_done(n);
         chk($sformatf("r%0d_lat", i), 64'(n), 64'(model_lat(rop, rb)));
         chk($sformatf("r%0d_hilo", i), {bus.hi, bus.lo}, rres);
      end

      repeat (2) @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
